// File: rtl/port_rst_ctrl_pkg.sv
// Shared state encoding and sizing helpers for the AFU port soft-reset sequencer.
package port_rst_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_ASSERT  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RELEASE = 3'd4
  } t_rst_state;

  localparam int STATS_W = 16;

  // Bits needed for a down-counter that is loaded with (cycles - 1).
  function automatic int timer_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/port_rst_outstanding_cnt.sv
// Saturating up/down count of outstanding non-posted AFU requests, with synchronous clear.
module port_rst_outstanding_cnt #(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt
);

  // Simultaneous issue and completion cancel; a completion at zero is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !dec && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end else if (dec && !inc && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/port_reset_ctrl.sv
// AFU port soft-reset sequencer: block, drain (with timeout), hold in reset, ack, release.
// Optional statistics counters are built when PORT_RST_CTRL_STATS_EN is defined.
//
// state   | meaning
// IDLE    | port running, requests allowed
// DRAIN   | new requests blocked, waiting for outstanding completions or timeout
// ASSERT  | AFU held in reset for MIN_RST_CYCLES, outstanding count forced to 0
// HOLD    | AFU in reset, ack to software, waiting for request to clear
// RELEASE | AFU out of reset, requests still blocked for one cycle
module port_reset_ctrl
  import port_rst_ctrl_pkg::*;
#(
  parameter int CNT_W          = 10,
  parameter int MIN_RST_CYCLES = 16,
  parameter int DRAIN_TIMEOUT  = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               port_rst_req,
  input  logic               err_clear,
  input  logic               tx_req_issue,
  input  logic               rx_cpl_done,
  output logic               afu_tx_block,
  output logic               afu_rst,
  output logic               port_rst_ack,
  output logic               drain_timeout_err,
  output logic [CNT_W-1:0]   outstanding_cnt,
  output logic [STATS_W-1:0] rst_seq_count,
  output logic [STATS_W-1:0] timeout_count
);

  localparam int TMR_W = (timer_width(DRAIN_TIMEOUT) > timer_width(MIN_RST_CYCLES)) ?
                         timer_width(DRAIN_TIMEOUT) : timer_width(MIN_RST_CYCLES);

  t_rst_state       state, next_state;
  logic [TMR_W-1:0] tmr;
  logic             timeout_evt;
  logic             assert_entry;
  logic             blk_d, arst_d, ack_d;

  assign assert_entry = (next_state == ST_ASSERT) && (state != ST_ASSERT);

  // Outputs are decoded from next_state so they change on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_HOLD;
      afu_tx_block <= 1'b1;
      afu_rst      <= 1'b1;
      port_rst_ack <= 1'b1;
    end else begin
      state        <= next_state;
      afu_tx_block <= blk_d;
      afu_rst      <= arst_d;
      port_rst_ack <= ack_d;
    end
  end

  always_comb begin
    next_state  = state;
    timeout_evt = 1'b0;
    case (state)
      ST_IDLE:    if (port_rst_req) next_state = ST_DRAIN;
      ST_DRAIN: begin
        if (outstanding_cnt == '0) begin
          next_state = ST_ASSERT;
        end else if (tmr == '0) begin
          next_state  = ST_ASSERT;
          timeout_evt = 1'b1;
        end
      end
      ST_ASSERT:  if (tmr == '0) next_state = ST_HOLD;
      ST_HOLD:    if (!port_rst_req) next_state = ST_RELEASE;
      ST_RELEASE: next_state = ST_IDLE;
      default:    next_state = ST_HOLD;
    endcase
  end

  always_comb begin
    blk_d  = 1'b1;
    arst_d = 1'b0;
    ack_d  = 1'b0;
    case (next_state)
      ST_IDLE:   blk_d = 1'b0;
      ST_ASSERT: arst_d = 1'b1;
      ST_HOLD: begin
        arst_d = 1'b1;
        ack_d  = 1'b1;
      end
      default: ;
    endcase
  end

  // One shared down-counter: drain budget in DRAIN, minimum reset width in ASSERT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr <= '0;
    end else if ((next_state == ST_DRAIN) && (state != ST_DRAIN)) begin
      tmr <= TMR_W'(DRAIN_TIMEOUT - 1);
    end else if (assert_entry) begin
      tmr <= TMR_W'(MIN_RST_CYCLES - 1);
    end else if (tmr != '0) begin
      tmr <= tmr - TMR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_timeout_err <= 1'b0;
    end else if (timeout_evt) begin
      drain_timeout_err <= 1'b1;
    end else if (err_clear) begin
      drain_timeout_err <= 1'b0;
    end
  end

  port_rst_outstanding_cnt #(
    .CNT_W (CNT_W)
  ) u_outstanding_cnt (
    .clk (clk),
    .rst (rst),
    .clr (next_state == ST_ASSERT),
    .inc (tx_req_issue),
    .dec (rx_cpl_done),
    .cnt (outstanding_cnt)
  );

`ifdef PORT_RST_CTRL_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_seq_count <= '0;
    end else if (assert_entry && (rst_seq_count != '1)) begin
      rst_seq_count <= rst_seq_count + STATS_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_count <= '0;
    end else if (timeout_evt && (timeout_count != '1)) begin
      timeout_count <= timeout_count + STATS_W'(1);
    end
  end
`else
  assign rst_seq_count = '0;
  assign timeout_count = '0;
`endif

endmodule

// File: tb/tb_port_reset_ctrl.sv
// Self-checking bench for port_reset_ctrl: per-cycle vector tables fed through an expected-value queue.
module tb_port_reset_ctrl;

  localparam int CNT_W = 10;
  localparam int MIN_RST = 16;
  localparam int DRAIN_TO = 4096;
  localparam int S_IDLE = 0, S_DRAIN = 1, S_ASSERT = 2, S_HOLD = 3, S_RELEASE = 4;

  logic clk = 1'b0;
  logic rst, port_rst_req, err_clear, tx_req_issue, rx_cpl_done;
  logic afu_tx_block, afu_rst, port_rst_ack, drain_timeout_err;
  logic [CNT_W-1:0] outstanding_cnt;
  logic [15:0] rst_seq_count, timeout_count;

  always #5 clk = ~clk;

  port_reset_ctrl #(
    .CNT_W          (CNT_W),
    .MIN_RST_CYCLES (MIN_RST),
    .DRAIN_TIMEOUT  (DRAIN_TO)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .port_rst_req      (port_rst_req),
    .err_clear         (err_clear),
    .tx_req_issue      (tx_req_issue),
    .rx_cpl_done       (rx_cpl_done),
    .afu_tx_block      (afu_tx_block),
    .afu_rst           (afu_rst),
    .port_rst_ack      (port_rst_ack),
    .drain_timeout_err (drain_timeout_err),
    .outstanding_cnt   (outstanding_cnt),
    .rst_seq_count     (rst_seq_count),
    .timeout_count     (timeout_count)
  );

  typedef struct {
    logic req, clr, iss, cpl;
    logic blk, arst, ack, err;
    logic [CNT_W-1:0] cnt;
  } vec_t;

  vec_t tbl[$];
  logic [CNT_W+3:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int exp_seq = 0;
  int exp_to = 0;

  // Expected outputs per state, straight from the state output table.
  function automatic void add(input logic req, input logic clr, input logic iss, input logic cpl,
                              input int st, input logic err, input int cnt);
    vec_t v;
    v.req = req; v.clr = clr; v.iss = iss; v.cpl = cpl;
    v.blk  = (st != S_IDLE);
    v.arst = (st == S_ASSERT) || (st == S_HOLD);
    v.ack  = (st == S_HOLD);
    v.err  = err;
    v.cnt  = CNT_W'(cnt);
    tbl.push_back(v);
  endfunction

  task automatic run_table(input string nm);
    for (int i = 0; i < tbl.size(); i++) begin
      logic [CNT_W+3:0] e, a;
      port_rst_req = tbl[i].req;
      err_clear    = tbl[i].clr;
      tx_req_issue = tbl[i].iss;
      rx_cpl_done  = tbl[i].cpl;
      exp_q.push_back({tbl[i].blk, tbl[i].arst, tbl[i].ack, tbl[i].err, tbl[i].cnt});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      a = {afu_tx_block, afu_rst, port_rst_ack, drain_timeout_err, outstanding_cnt};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s[%0d]: got blk/rst/ack/err=%b%b%b%b cnt=%0d, expected %b%b%b%b cnt=%0d",
                 nm, i, a[CNT_W+3], a[CNT_W+2], a[CNT_W+1], a[CNT_W], a[CNT_W-1:0],
                 e[CNT_W+3], e[CNT_W+2], e[CNT_W+1], e[CNT_W], e[CNT_W-1:0]);
      end
    end
    tbl.delete();
    err_clear    = 1'b0;
    tx_req_issue = 1'b0;
    rx_cpl_done  = 1'b0;
  endtask

  task automatic check1(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; port_rst_req = 1'b1; err_clear = 1'b0; tx_req_issue = 1'b0; rx_cpl_done = 1'b0;
    #2;
    check1("reset_blk", int'(afu_tx_block), 1);
    check1("reset_afu_rst", int'(afu_rst), 1);
    check1("reset_ack", int'(port_rst_ack), 1);
    check1("reset_err", int'(drain_timeout_err), 0);
    check1("reset_cnt", int'(outstanding_cnt), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Power-up hold, then release on request clear.
    repeat (3) add(1, 0, 0, 0, S_HOLD, 0, 0);
    add(0, 0, 0, 0, S_RELEASE, 0, 0);
    repeat (2) add(0, 0, 0, 0, S_IDLE, 0, 0);
    run_table("powerup");

    // Empty drain; request dropped during DRAIN still completes through HOLD.
    add(1, 0, 0, 0, S_DRAIN, 0, 0);
    repeat (MIN_RST) add(0, 0, 0, 0, S_ASSERT, 0, 0);
    add(0, 0, 0, 0, S_HOLD, 0, 0);
    add(0, 0, 0, 0, S_RELEASE, 0, 0);
    repeat (2) add(0, 0, 0, 0, S_IDLE, 0, 0);
    run_table("min_latency");
    exp_seq++;

    // Drain of five spaced completions.
    for (int c = 1; c <= 5; c++) add(0, 0, 1, 0, S_IDLE, 0, c);
    add(1, 0, 0, 0, S_DRAIN, 0, 5);
    for (int c = 0; c < 5; c++) begin
      add(1, 0, 0, 1, S_DRAIN, 0, 4 - c);
      if (c < 4) repeat (9) add(1, 0, 0, 0, S_DRAIN, 0, 4 - c);
    end
    repeat (MIN_RST) add(1, 0, 0, 0, S_ASSERT, 0, 0);
    repeat (3) add(1, 0, 0, 0, S_HOLD, 0, 0);
    add(0, 0, 0, 0, S_RELEASE, 0, 0);
    repeat (2) add(0, 0, 0, 0, S_IDLE, 0, 0);
    run_table("drain");
    exp_seq++;

    // Timeout with three stuck requests, then err_clear.
    for (int c = 1; c <= 3; c++) add(0, 0, 1, 0, S_IDLE, 0, c);
    repeat (DRAIN_TO) add(1, 0, 0, 0, S_DRAIN, 0, 3);
    add(1, 0, 0, 0, S_ASSERT, 1, 0);
    add(1, 1, 0, 0, S_ASSERT, 0, 0);
    repeat (MIN_RST - 2) add(1, 0, 0, 0, S_ASSERT, 0, 0);
    repeat (2) add(1, 0, 0, 0, S_HOLD, 0, 0);
    add(0, 0, 0, 0, S_RELEASE, 0, 0);
    repeat (2) add(0, 0, 0, 0, S_IDLE, 0, 0);
    run_table("timeout");
    exp_seq++; exp_to++;

    // Second timeout with err_clear in the timeout cycle: set wins.
    add(0, 0, 1, 0, S_IDLE, 0, 1);
    repeat (DRAIN_TO) add(1, 0, 0, 0, S_DRAIN, 0, 1);
    add(1, 1, 0, 0, S_ASSERT, 1, 0);
    repeat (MIN_RST - 1) add(1, 0, 0, 0, S_ASSERT, 1, 0);
    add(1, 0, 0, 0, S_HOLD, 1, 0);
    add(0, 1, 0, 0, S_RELEASE, 0, 0);
    repeat (2) add(0, 0, 0, 0, S_IDLE, 0, 0);
    run_table("timeout_setwins");
    exp_seq++; exp_to++;

    // Counter corners: cancel, completion at zero, saturation.
    add(0, 0, 1, 0, S_IDLE, 0, 1);
    add(0, 0, 1, 1, S_IDLE, 0, 1);
    add(0, 0, 0, 1, S_IDLE, 0, 0);
    add(0, 0, 0, 1, S_IDLE, 0, 0);
    add(0, 0, 1, 1, S_IDLE, 0, 0);
    for (int i = 1; i <= 1023; i++) add(0, 0, 1, 0, S_IDLE, 0, i);
    repeat (2) add(0, 0, 1, 0, S_IDLE, 0, 1023);
    run_table("counter");

`ifdef PORT_RST_CTRL_STATS_EN
    check1("rst_seq_count", int'(rst_seq_count), exp_seq);
    check1("timeout_count", int'(timeout_count), exp_to);
`else
    check1("rst_seq_count_off", int'(rst_seq_count), 0);
    check1("timeout_count_off", int'(timeout_count), 0);
`endif

    // Async reset mid-DRAIN lands straight in HOLD.
    repeat (3) add(1, 0, 0, 0, S_DRAIN, 0, 1023);
    run_table("pre_reset_drain");
    rst = 1'b1;
    #1;
    check1("midreset_blk", int'(afu_tx_block), 1);
    check1("midreset_afu_rst", int'(afu_rst), 1);
    check1("midreset_ack", int'(port_rst_ack), 1);
    check1("midreset_cnt", int'(outstanding_cnt), 0);
    check1("midreset_seq", int'(rst_seq_count), 0);
    check1("midreset_to", int'(timeout_count), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    add(1, 0, 0, 0, S_HOLD, 0, 0);
    add(0, 0, 0, 0, S_RELEASE, 0, 0);
    add(0, 0, 0, 0, S_IDLE, 0, 0);
    run_table("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
